decim_avg_mc: RTL

//  Multi-channel boxcar-average decimator for the ADC capture path. Accumulates
//  2^R valid samples per channel, with R selectable at run time, and emits one

---
 rtl/decim_avg_mc.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/decim_avg_mc.sv
`default_nettype none
// ============================================================================
// Module   : decim_avg_mc
// Purpose  : Multi-channel boxcar-average decimator. Sums 2^R valid samples
//            per channel (R latched at the start of each window) and emits
//            one averaged word per channel per window over a valid/ready
//            output register. A window that completes while the output
//            register is stalled is dropped and flags a sticky overrun.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            ena              - enable; low aborts the open window
//            log2_ratio       - R request, values above MAX_LOG2_RATIO clamp
//            in_valid/in_data - aligned signed samples, ch0 in the LSBs
//            out_valid/out_ready - result handshake
//            out_data_s       - signed averages
//            out_data_u       - offset-binary averages (lane MSB inverted)
//            overrun          - sticky, a result was dropped
//            win_cnt          - samples accepted in the current window
// Config   : define DECIM_ROUND_EN for round-half-up averaging; otherwise
//            the average is floored.
// Revision : 1.0 - initial release
// ============================================================================
module decim_avg_mc #(
  parameter int DATA_WIDTH     = 14,
  parameter int NUM_CH         = 2,
  parameter int MAX_LOG2_RATIO = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ena,
  input  logic [$clog2(MAX_LOG2_RATIO+1)-1:0]    log2_ratio,
  input  logic                                   in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]           in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0]           out_data_s,
  output logic [NUM_CH*DATA_WIDTH-1:0]           out_data_u,
  output logic                                   overrun,
  output logic [MAX_LOG2_RATIO-1:0]              win_cnt
);

  localparam int RW    = $clog2(MAX_LOG2_RATIO + 1);
  localparam int DW    = DATA_WIDTH;
  localparam int ACC_W = DATA_WIDTH + MAX_LOG2_RATIO + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t                           state_q, state_d;
  logic [RW-1:0]                    r_active_q, r_active_d;
  logic [NUM_CH-1:0][ACC_W-1:0]     acc_q, acc_d;
  logic [MAX_LOG2_RATIO-1:0]        win_cnt_q, win_cnt_d;
  logic                             out_valid_q, out_valid_d;
  logic [NUM_CH*DW-1:0]             out_data_s_q, out_data_s_d;
  logic                             overrun_q, overrun_d;

  logic [RW-1:0]                    r_req;
  logic [RW-1:0]                    r_eff;
  logic [MAX_LOG2_RATIO:0]          win_len;
  logic [MAX_LOG2_RATIO:0]          cnt_next;
  logic                             win_done;
  logic [NUM_CH-1:0][ACC_W-1:0]     lane_sum;
  logic [NUM_CH-1:0][DW-1:0]        lane_res;

  assign r_req    = (log2_ratio > RW'(MAX_LOG2_RATIO)) ? RW'(MAX_LOG2_RATIO) : log2_ratio;
  // The first sample of a window is processed with the freshly requested R;
  // later samples use the value latched when the window opened.
  assign r_eff    = (state_q == ST_IDLE) ? r_req : r_active_q;
  assign win_len  = {{MAX_LOG2_RATIO{1'b0}}, 1'b1} << r_active_q;
  assign cnt_next = {1'b0, win_cnt_q} + {{MAX_LOG2_RATIO{1'b0}}, 1'b1};
  // With R = 0 the opening sample is also the closing one.
  assign win_done = ena && in_valid &&
                    ((state_q == ST_IDLE) ? (r_req == '0) : (cnt_next == win_len));

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    logic signed [ACC_W-1:0] samp;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] shifted;
    logic                    unused_hi;

    assign samp = {{(ACC_W-DW){in_data[ch*DW+DW-1]}}, in_data[ch*DW +: DW]};
    assign sum  = ((state_q == ST_ACCUM) ? acc_q[ch] : '0) + samp;
`ifdef DECIM_ROUND_EN
    assign biased = (r_eff == '0) ? sum : sum + (ACC_W'(1) << (r_eff - RW'(1)));
`else
    assign biased = sum;
`endif
    // Arithmetic shift floors toward minus infinity for negative sums.
    assign shifted      = biased >>> r_eff;
    assign lane_sum[ch] = sum;
    assign lane_res[ch] = shifted[DW-1:0];
    // The average of in-range samples always fits DW bits; the top bits
    // are only sign copies.
    assign unused_hi    = ^shifted[ACC_W-1:DW];

    assign out_data_u[ch*DW +: DW] = {~out_data_s_q[ch*DW+DW-1], out_data_s_q[ch*DW +: DW-1]};
  end

  always_comb begin
    state_d      = state_q;
    r_active_d   = r_active_q;
    acc_d        = acc_q;
    win_cnt_d    = win_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_s_d = out_data_s_q;
    overrun_d    = overrun_q;

    // Window accumulation
    if (!ena) begin
      state_d   = ST_IDLE;
      acc_d     = '0;
      win_cnt_d = '0;
    end else if (in_valid) begin
      if (win_done) begin
        state_d   = ST_IDLE;
        acc_d     = '0;
        win_cnt_d = '0;
      end else if (state_q == ST_IDLE) begin
        state_d    = ST_ACCUM;
        r_active_d = r_req;
        acc_d      = lane_sum;
        win_cnt_d  = {{(MAX_LOG2_RATIO-1){1'b0}}, 1'b1};
      end else begin
        acc_d     = lane_sum;
        win_cnt_d = cnt_next[MAX_LOG2_RATIO-1:0];
      end
    end

    // Output register: a stalled, full register keeps its data and the new
    // result is lost.
    if (win_done) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d  = 1'b1;
        out_data_s_d = lane_res;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      r_active_q   <= '0;
      acc_q        <= '0;
      win_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_s_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_active_q   <= r_active_d;
      acc_q        <= acc_d;
      win_cnt_q    <= win_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_s_q <= out_data_s_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data_s = out_data_s_q;
  assign overrun    = overrun_q;
  assign win_cnt    = win_cnt_q;

endmodule
`default_nettype wire
